serv_dbus_resp: RTL and testbench

Wishbone-classic data-bus responder (slave) for the SERV core's dbus initiator. It accepts single read/write cycles from the core's cyc/we/sel/adr/dat signals and serves them from an internal byte-addressable RAM. It returns a single-cycle registered ack after a configurable number of wait states. It is used as the simulation/FPGA data memory and as the reference responder for dbus handshake verification.

---
 rtl/serv_dbus_resp.sv | 129 ++++++++++++
 tb/tb_serv_dbus_resp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_resp.sv
`timescale 1ns/1ps
// serv_dbus_resp: Wishbone-classic dbus responder for the SERV core, served from an internal RAM.
// Define SERV_DBUS_RESP_ERR_EN to flag out-of-range addresses with o_wb_err instead of wrapping.
module serv_dbus_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_wb_err
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          WORDS    = DEPTH / 4;
    localparam int          IW       = (AW > 2) ? AW - 2 : 1;
    localparam logic [31:0] ADR_MASK = 32'((64'd1 << AW) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          err_q, err_d;
    logic [31:0]   mem [WORDS];

    logic [IW-1:0] word_idx;
    logic          out_of_range;
    logic          enter_ack;
    logic          mem_we;

    assign word_idx = IW'((i_wb_adr & ADR_MASK) >> 2);

`ifdef SERV_DBUS_RESP_ERR_EN
    assign out_of_range = (i_wb_adr & ~ADR_MASK) != 32'd0;
`else
    assign out_of_range = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wb_cyc) begin
                    if (WAIT_STATES == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data and error are captured on the edge entering ACK; writes leave rdt untouched.
    always_comb begin
        rdt_d = rdt_q;
        err_d = 1'b0;
        if (enter_ack) begin
            if (out_of_range) begin
                rdt_d = '0;
                err_d = 1'b1;
            end else if (!i_wb_we) begin
                rdt_d = mem[word_idx];
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdt_q   <= rdt_d;
            err_q   <= err_d;
        end
    end

    // A clock edge during reset must not commit a write even though the FSM decode sees cyc.
    assign mem_we = enter_ack && i_wb_we && !out_of_range && !i_rst;

    // NOTE: the RAM is deliberately not reset; it maps onto plain RAM blocks and holds contents.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (i_wb_sel[n]) begin
                    mem[word_idx][8*n +: 8] <= i_wb_dat[8*n +: 8];
                end
            end
        end
    end

    assign o_wb_ack = (state_q == ACK);
    assign o_wb_rdt = rdt_q;
    assign o_wb_err = err_q;

endmodule

// File: tb/tb_serv_dbus_resp.sv
`timescale 1ns/1ps
// Self-checking bench for serv_dbus_resp: one responder with 0 wait states, one with 3,
// directed vectors for handshake corners, then random traffic against a byte-array model.
module tb_serv_dbus_resp;
    localparam int DEPTH = 1024;
`ifdef SERV_DBUS_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       cyc, we, ack, err;
    logic [1:0][31:0] adr, dat, rdt;
    logic [1:0][3:0]  sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a flat byte memory per responder plus the last value the read port should hold.
    logic [7:0]  mdl [2][DEPTH];
    logic [31:0] mdl_rdt [2];

    always #5 clk = ~clk;

    serv_dbus_resp #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cyc(cyc[0]), .i_wb_we(we[0]), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .i_wb_sel(sel[0]),
        .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0])
    );

    serv_dbus_resp #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cyc(cyc[1]), .i_wb_we(we[1]), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .i_wb_sel(sel[1]),
        .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return ERR_EN && ((a / DEPTH) != 0);
    endfunction

    function automatic logic [31:0] mdl_read(input int w, input logic [31:0] a);
        int base;
        base = int'(a % DEPTH) & ~3;
        return {mdl[w][base+3], mdl[w][base+2], mdl[w][base+1], mdl[w][base]};
    endfunction

    task automatic mdl_apply(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int base;
        base = int'(a % DEPTH) & ~3;
        if (is_oor(a)) begin
            mdl_rdt[w] = '0;
        end else if (wr) begin
            for (int n = 0; n < 4; n++) if (s[n]) mdl[w][base+n] = d[8*n +: 8];
        end else begin
            mdl_rdt[w] = mdl_read(w, a);
        end
    endtask

    // One complete Wishbone cycle; checks latency and one-cycle ack width, returns rdt/err seen with ack.
    task automatic do_cycle(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r, output logic e);
        int lat;
        int lat_exp;
        bit got;
        lat_exp = (w == 0) ? 1 : 4;
        @(negedge clk);
        cyc[w] = 1'b1; we[w] = wr; adr[w] = a; dat[w] = d; sel[w] = s;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack[w] === 1'b1) got = 1'b1;
        end
        r = rdt[w];
        e = err[w];
        cyc[w] = 1'b0;
        we[w]  = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("ack_latency", lat, lat_exp);
            mdl_apply(w, wr, a, d, s);
            @(posedge clk);
            #1;
            check("ack_width", ack[w], 32'd0);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rdt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] r;
        logic        e;
        logic [5:0]  pat;
        int          n_ack;
        int          w;
        logic        wr;
        logic [31:0] a, d, exp_r;
        logic [3:0]  s;
        logic        exp_e;

        vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h020, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h024, 32'hCAFEF00D, 4'hF, 32'h11BB33DD, 1'b0};
        vecs[6]  = '{1'b1, 32'h024, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b0, 32'h027, 32'h0,        4'h3, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h000, 32'h12345678, 4'hF, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 32'h410, 32'h0,        4'h0, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN};
        vecs[10] = '{1'b1, 32'h400, 32'h87654321, 4'hF, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN};
        vecs[11] = '{1'b0, 32'h000, 32'h0,        4'hF, ERR_EN ? 32'h12345678 : 32'h87654321, 1'b0};

        rst = 1'b1;
        cyc = '0; we = '0; adr = '0; dat = '0; sel = '0;
        mdl_rdt[0] = '0;
        mdl_rdt[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_ack", ack[i], 32'd0);
            check("reset_rdt", rdt[i], 32'd0);
            check("reset_err", err[i], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table vectors on the zero-wait responder.
        for (int i = 0; i < 12; i++) begin
            do_cycle(0, vecs[i].wr, vecs[i].adr, vecs[i].dat, vecs[i].sel, r, e);
            check($sformatf("vec%0d_rdt", i), r, vecs[i].exp_rdt);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
        end

        // cyc held high continuously: acks every other cycle because of the turnaround.
        @(negedge clk);
        cyc[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10; sel[0] = 4'h0;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            pat[i] = ack[0];
        end
        cyc[0] = 1'b0;
        check("b2b_ack_pattern", pat, 32'b010101);
        check("b2b_rdt", rdt[0], 32'hDEADBEEF);
        mdl_rdt[0] = mdl_read(0, 32'h10);

        // Three wait states: write then read back.
        do_cycle(1, 1'b1, 32'h10, 32'h0BADCAFE, 4'hF, r, e);
        do_cycle(1, 1'b0, 32'h10, 32'h0, 4'hF, r, e);
        check("ws3_read", r, 32'h0BADCAFE);

        // Abort: cyc dropped during WAIT, no ack and no write.
        do_cycle(1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, r, e);
        @(negedge clk);
        cyc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; dat[1] = 32'h11111111; sel[1] = 4'hF;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_wait_ack", ack[1], 32'd0);
        end
        cyc[1] = 1'b0;
        we[1]  = 1'b0;
        n_ack = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            n_ack += int'(ack[1]);
        end
        check("abort_no_ack", n_ack, 32'd0);
        do_cycle(1, 1'b0, 32'h30, 32'h0, 4'hF, r, e);
        check("abort_mem_kept", r, 32'h5A5A5A5A);

        // Async reset in WAIT, held across edges with cyc still high, released between edges.
        do_cycle(1, 1'b1, 32'h34, 32'h76543210, 4'hF, r, e);
        do_cycle(1, 1'b0, 32'h34, 32'h0, 4'hF, r, e);
        check("rst_pre_read", r, 32'h76543210);
        @(negedge clk);
        cyc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h34; dat[1] = 32'h99999999; sel[1] = 4'hF;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_ack", ack[1], 32'd0);
        check("rst_async_rdt", rdt[1], 32'd0);
        check("rst_async_rdt0", rdt[0], 32'd0);
        repeat (2) @(posedge clk);
        #3;
        cyc[1] = 1'b0;
        we[1]  = 1'b0;
        #1;
        rst = 1'b0;
        mdl_rdt[0] = '0;
        mdl_rdt[1] = '0;
        n_ack = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            n_ack += int'(ack[1]);
        end
        check("rst_no_ack", n_ack, 32'd0);
        do_cycle(1, 1'b0, 32'h34, 32'h0, 4'hF, r, e);
        check("rst_no_write", r, 32'h76543210);

        // Random traffic: fill the low 256 bytes, then mixed reads/writes with occasional high bits.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                do_cycle(k, 1'b1, 32'(i * 4), $urandom(), 4'hF, r, e);
            end
        end
        for (int k = 0; k < 300; k++) begin
            w  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = $urandom();
            a  = $urandom() & 32'h0000_00FF;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom() & 32'hFFFF_FC00);
            exp_e = is_oor(a);
            exp_r = exp_e ? 32'h0 : (wr ? mdl_rdt[w] : mdl_read(w, a));
            do_cycle(w, wr, a, d, s, r, e);
            check("rand_rdt", r, exp_r);
            check("rand_err", e, exp_e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
